// File: rtl/systolic_pe_mac_if.sv
// Bus bundle between the systolic controller / neighbours and one PE:
// job control (start, clr), streamed operands, forwarded operands and
// job status. master = controller/array side, slave = the PE itself.
interface systolic_pe_mac_if #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20
) ();
   logic                     start;
   logic                     clr;
   logic signed [DATA_W-1:0] a_in;
   logic signed [DATA_W-1:0] b_in;
   logic signed [DATA_W-1:0] a_out;
   logic signed [DATA_W-1:0] b_out;
   logic signed [ACC_W-1:0]  acc_out;
   logic                     busy;
   logic                     done;
   logic                     delayed_done;
   logic                     ovf;

   modport master (
      output start, clr, a_in, b_in,
      input  a_out, b_out, acc_out, busy, done, delayed_done, ovf
   );

   modport slave (
      input  start, clr, a_in, b_in,
      output a_out, b_out, acc_out, busy, done, delayed_done, ovf
   );
endinterface

// File: rtl/systolic_pe_mac.sv
// Systolic-array processing element: on a start pulse performs K_LEN signed
// MACs of the west/north operands, forwards operands east/south through a
// one-cycle register, then reports done and, DONE_DELAY cycles later,
// delayed_done. FSM: IDLE -> RUN (K_LEN cycles) -> WAIT (DONE_DELAY cycles).
// Optional build macro PE_SATURATE_EN: when defined the accumulator clamps
// to the signed ACC_W range and sets the sticky ovf flag; otherwise the
// accumulator wraps and ovf stays 0.
module systolic_pe_mac #(
   parameter int DATA_W     = 8,
   parameter int ACC_W      = 20,
   parameter int K_LEN      = 4,
   parameter int DONE_DELAY = 2
) (
   input logic              clk,
   input logic              rst,
   systolic_pe_mac_if.slave pe
);

   localparam int KW = (K_LEN > 1) ? $clog2(K_LEN) : 1;
   localparam int DW = (DONE_DELAY > 1) ? $clog2(DONE_DELAY) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(K_LEN - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DONE_DELAY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t state_reg, state_next;

   logic [KW-1:0] k_cnt_reg, k_cnt_next;
   logic [DW-1:0] d_cnt_reg, d_cnt_next;

   logic signed [ACC_W-1:0]  acc_reg, acc_next;
   logic                     ovf_reg, ovf_next;
   logic                     done_reg, done_next;
   logic                     dly_reg, dly_next;
   logic                     busy_reg, busy_next;
   logic signed [DATA_W-1:0] a_fwd_reg, b_fwd_reg;

   // ---------------------------------------------------------------
   // MAC datapath: full-width signed product, sign-extended, then added
   // ---------------------------------------------------------------
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    mac_result;
   logic                       sat_hit;

   assign prod     = pe.a_in * pe.b_in;
   assign prod_ext = ACC_W'(prod);

`ifdef PE_SATURATE_EN
   // One extra bit exposes signed overflow: the top two bits disagree.
   logic signed [ACC_W:0] sum_wide;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   assign sum_wide = (ACC_W+1)'(acc_reg) + (ACC_W+1)'(prod_ext);

   // Clamp to the signed range whenever the wide sum leaves it
   always_comb begin
      sat_hit    = (sum_wide[ACC_W] != sum_wide[ACC_W-1]);
      mac_result = sum_wide[ACC_W-1:0];
      if (sat_hit) begin
         mac_result = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
      end
   end
`else
   // Plain two's-complement wrap; overflow is never reported
   always_comb begin
      sat_hit    = 1'b0;
      mac_result = acc_reg + prod_ext;
   end
`endif

   // ---------------------------------------------------------------
   // FSM process 1: state register
   // ---------------------------------------------------------------
   // State advances every edge; reset aborts any job back to IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------------------------------------------------------
   // FSM process 2: next-state logic
   // ---------------------------------------------------------------
   // Start only matters in IDLE; RUN/WAIT are fixed-length
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (pe.start)            state_next = ST_RUN;
         ST_RUN:  if (k_cnt_reg == K_LAST) state_next = ST_WAIT;
         ST_WAIT: if (d_cnt_reg == D_LAST) state_next = ST_IDLE;
         default:                          state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // FSM process 3: output / datapath next values
   // ---------------------------------------------------------------
   // Outputs are registered, so here we compute what they become next edge
   always_comb begin
      acc_next   = acc_reg;
      ovf_next   = ovf_reg;
      k_cnt_next = k_cnt_reg;
      d_cnt_next = d_cnt_reg;
      done_next  = 1'b0;
      dly_next   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // clr and start together: clear now, the job then accumulates from 0
            if (pe.clr) begin
               acc_next = '0;
               ovf_next = 1'b0;
            end
            k_cnt_next = '0;
         end
         ST_RUN: begin
            acc_next   = mac_result;
            ovf_next   = ovf_reg | sat_hit;
            k_cnt_next = k_cnt_reg + 1'b1;
            if (k_cnt_reg == K_LAST) begin
               d_cnt_next = '0;
               done_next  = 1'b1;
            end
         end
         ST_WAIT: begin
            d_cnt_next = d_cnt_reg + 1'b1;
            if (d_cnt_reg == D_LAST) begin
               dly_next = 1'b1;
            end
         end
         default: begin
            k_cnt_next = '0;
            d_cnt_next = '0;
         end
      endcase
      busy_next = (state_next != ST_IDLE);
   end

   // Registers for counters, accumulator and status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         k_cnt_reg <= '0;
         d_cnt_reg <= '0;
         acc_reg   <= '0;
         ovf_reg   <= 1'b0;
         done_reg  <= 1'b0;
         dly_reg   <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         k_cnt_reg <= k_cnt_next;
         d_cnt_reg <= d_cnt_next;
         acc_reg   <= acc_next;
         ovf_reg   <= ovf_next;
         done_reg  <= done_next;
         dly_reg   <= dly_next;
         busy_reg  <= busy_next;
      end
   end

   // Operand forwarding to east/south neighbours, independent of FSM state
   always_ff @(posedge clk) begin
      if (rst) begin
         a_fwd_reg <= '0;
         b_fwd_reg <= '0;
      end else begin
         a_fwd_reg <= pe.a_in;
         b_fwd_reg <= pe.b_in;
      end
   end

   assign pe.a_out        = a_fwd_reg;
   assign pe.b_out        = b_fwd_reg;
   assign pe.acc_out      = acc_reg;
   assign pe.busy         = busy_reg;
   assign pe.done         = done_reg;
   assign pe.delayed_done = dly_reg;
   assign pe.ovf          = ovf_reg;

endmodule

// File: tb/tb_systolic_pe_mac.sv
// Directed self-checking bench for systolic_pe_mac. Instance u0 uses the
// default parameters; u1 uses ACC_W=16 to exercise overflow behaviour.
module tb_systolic_pe_mac;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   systolic_pe_mac_if #(.DATA_W(8), .ACC_W(20)) if0 ();
   systolic_pe_mac_if #(.DATA_W(8), .ACC_W(16)) if1 ();

   systolic_pe_mac #(.DATA_W(8), .ACC_W(20), .K_LEN(4), .DONE_DELAY(2)) u0 (
      .clk (clk),
      .rst (rst),
      .pe  (if0)
   );

   systolic_pe_mac #(.DATA_W(8), .ACC_W(16), .K_LEN(4), .DONE_DELAY(2)) u1 (
      .clk (clk),
      .rst (rst),
      .pe  (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one edge and settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s got=%0d expected=%0d", name, got, exp);
      end else begin
         $display("[TB] ok   %s = %0d", name, got);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      tests_run++;
      if (if0.acc_out !== 20'sd0) begin
         tests_failed++; $display("[TB] FAIL reset_acc got=%0d expected=0", if0.acc_out);
      end else $display("[TB] ok   reset_acc");
      tests_run++;
      if ({if0.busy, if0.done, if0.delayed_done, if0.ovf} !== 4'b0000) begin
         tests_failed++; $display("[TB] FAIL reset_flags got=%b expected=0000",
                                  {if0.busy, if0.done, if0.delayed_done, if0.ovf});
      end else $display("[TB] ok   reset_flags");
      tests_run++;
      if (if0.a_out !== 8'sd0 || if0.b_out !== 8'sd0) begin
         tests_failed++; $display("[TB] FAIL reset_fwd got=%0d/%0d expected=0/0", if0.a_out, if0.b_out);
      end else $display("[TB] ok   reset_fwd");
      rst = 1'b0;
      tick();
   endtask

   // start at edge t; operands in cycles 1..4; check every cycle up to 7
   task automatic test_mac_job();
      int av[4] = '{1, 2, 3, 4};
      int bv[4] = '{5, 6, 7, 8};
      if0.start = 1'b1;
      tick();
      if0.start = 1'b0;
      for (int cyc = 1; cyc <= 7; cyc++) begin
         if (cyc <= 4) begin
            if0.a_in = 8'(av[cyc-1]);
            if0.b_in = 8'(bv[cyc-1]);
         end else begin
            if0.a_in = 8'sd0;
            if0.b_in = 8'sd0;
         end
         if (if0.busy !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL job1_busy cycle=%0d got=%b expected=1", cyc, if0.busy);
         end
         if (cyc < 7) tick();
         // now in cycle cyc+1
         if (cyc == 4) begin
            check("job1_done_at_t5", 32'(if0.done), 1);
            check("job1_acc_final", 32'(if0.acc_out), 70);
         end
         if (cyc == 5) check("job1_done_clears", 32'(if0.done), 0);
         if (cyc == 6) begin
            check("job1_dly_at_t7", 32'(if0.delayed_done), 1);
            check("job1_busy_low_t7", 32'(if0.busy), 0);
            break;
         end
      end
      tick();
      check("job1_dly_pulse", 32'(if0.delayed_done), 0);
   endtask

   task automatic test_accumulate();
      if0.start = 1'b1;
      tick();
      if0.start = 1'b0;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         if0.a_in = -8'sd3;
         if0.b_in = 8'sd4;
         tick();
      end
      if0.a_in = 8'sd0;
      if0.b_in = 8'sd0;
      check("job2_done", 32'(if0.done), 1);
      check("job2_acc", 32'(if0.acc_out), 22);
      tick();
      tick();
      check("job2_idle", 32'(if0.busy), 0);
      if0.clr = 1'b1;
      tick();
      if0.clr = 1'b0;
      check("clr_acc", 32'(if0.acc_out), 0);
   endtask

   task automatic test_forward();
      int av[3] = '{'h11, 'h22, 'h33};
      int bv[3] = '{'h0A, 'h0B, 'h0C};
      // idle streaming
      for (int i = 0; i < 3; i++) begin
         if0.a_in = 8'(av[i]);
         if0.b_in = 8'(bv[i]);
         tick();
         check("fwd_idle_a", 32'(if0.a_out), av[i]);
         check("fwd_idle_b", 32'(if0.b_out), bv[i]);
      end
      // streaming through RUN and WAIT with b=0 so acc stays 0
      if0.start = 1'b1;
      if0.b_in  = 8'sd0;
      tick();
      if0.start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if0.a_in = 8'(av[i % 3]);
         tick();
         check("fwd_job_a", 32'(if0.a_out), av[i % 3]);
      end
      check("fwd_job_acc", 32'(if0.acc_out), 0);
      if0.a_in = 8'sd0;
      tick();
   endtask

   task automatic test_ignore_start();
      int av[4] = '{1, 2, 3, 4};
      int bv[4] = '{5, 6, 7, 8};
      int n_done = 0;
      int n_dly  = 0;
      if0.start = 1'b1;
      tick();
      for (int cyc = 1; cyc <= 12; cyc++) begin
         if0.start = (cyc == 2 || cyc == 5);
         if0.clr   = (cyc == 3);
         if (cyc <= 4) begin
            if0.a_in = 8'(av[cyc-1]);
            if0.b_in = 8'(bv[cyc-1]);
         end else begin
            if0.a_in = 8'sd0;
            if0.b_in = 8'sd0;
         end
         tick();
         if (if0.done === 1'b1) n_done++;
         if (if0.delayed_done === 1'b1) n_dly++;
      end
      if0.start = 1'b0;
      if0.clr   = 1'b0;
      check("ign_done_count", n_done, 1);
      check("ign_dly_count", n_dly, 1);
      check("ign_acc", 32'(if0.acc_out), 70);
      check("ign_busy_end", 32'(if0.busy), 0);
      if0.clr = 1'b1;
      tick();
      if0.clr = 1'b0;
   endtask

   task automatic test_rst_mid();
      int n_done = 0;
      int n_dly  = 0;
      if0.start = 1'b1;
      tick();
      if0.start = 1'b0;
      if0.a_in  = 8'sd1;
      if0.b_in  = 8'sd1;
      tick();
      // cycle t+2: reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstmid_busy", 32'(if0.busy), 0);
      check("rstmid_acc", 32'(if0.acc_out), 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         if (if0.done === 1'b1) n_done++;
         if (if0.delayed_done === 1'b1) n_dly++;
         if (if0.busy === 1'b1) n_done++;
      end
      check("rstmid_no_pulses", n_done + n_dly, 0);
      if0.start = 1'b1;
      tick();
      if0.start = 1'b0;
      if0.a_in  = 8'sd2;
      if0.b_in  = 8'sd3;
      for (int i = 0; i < 4; i++) tick();
      check("rstmid_rerun_done", 32'(if0.done), 1);
      check("rstmid_rerun_acc", 32'(if0.acc_out), 24);
      if0.a_in = 8'sd0;
      if0.b_in = 8'sd0;
      tick();
      tick();
      if0.clr = 1'b1;
      tick();
      if0.clr = 1'b0;
   endtask

   task automatic test_back_to_back();
      if0.a_in  = 8'sd1;
      if0.b_in  = 8'sd1;
      if0.start = 1'b1;
      tick();
      if0.start = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("b2b_dly_first", 32'(if0.delayed_done), 1);
      check("b2b_acc_first", 32'(if0.acc_out), 4);
      if0.start = 1'b1;
      tick();
      if0.start = 1'b0;
      check("b2b_busy_second", 32'(if0.busy), 1);
      for (int i = 0; i < 4; i++) tick();
      check("b2b_done_second", 32'(if0.done), 1);
      check("b2b_acc_second", 32'(if0.acc_out), 8);
      if0.a_in = 8'sd0;
      if0.b_in = 8'sd0;
      tick();
      tick();
   endtask

   task automatic test_saturate();
      int exp_acc;
      int exp_ovf;
`ifdef PE_SATURATE_EN
      exp_acc = 32767;
      exp_ovf = 1;
`else
      exp_acc = -1020;
      exp_ovf = 0;
`endif
      if1.start = 1'b1;
      tick();
      if1.start = 1'b0;
      if1.a_in  = 8'sd127;
      if1.b_in  = 8'sd127;
      for (int i = 0; i < 4; i++) tick();
      if1.a_in = 8'sd0;
      if1.b_in = 8'sd0;
      check("sat_done", 32'(if1.done), 1);
      check("sat_acc", 32'(if1.acc_out), exp_acc);
      check("sat_ovf", 32'(if1.ovf), exp_ovf);
      tick();
      tick();
      if1.clr = 1'b1;
      tick();
      if1.clr = 1'b0;
      check("sat_clr_acc", 32'(if1.acc_out), 0);
      check("sat_clr_ovf", 32'(if1.ovf), 0);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst       = 1'b1;
      if0.start = 1'b0;  if0.clr = 1'b0;  if0.a_in = '0;  if0.b_in = '0;
      if1.start = 1'b0;  if1.clr = 1'b0;  if1.a_in = '0;  if1.b_in = '0;
      test_reset();
      test_mac_job();
      test_accumulate();
      test_forward();
      test_ignore_start();
      test_rst_mid();
      test_back_to_back();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/systolic_pe_mac.md
Name: systolic_pe_mac

Overview:
Processing element for the 2x2 systolic array. It responds to the controller's one-cycle start pulse by performing K_LEN signed multiply-accumulates on operands streamed in from the west (a) and north (b). Operands are forwarded east and south through one-cycle registers. On completion it returns done, then delayed_done DONE_DELAY cycles later; the controller uses delayed_done to launch the next wavefront. It also honours the controller's clr and rst.

Parameters:
DATA_W, 8, signed operand width
ACC_W, 20, signed accumulator width (must be >= 2*DATA_W)
K_LEN, 4, MACs per job (>= 1)
DONE_DELAY, 2, cycles from done to delayed_done (>= 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset: synchronous, active-high; priority over everything
clr  in  1  synchronous accumulator clear; acted on only in IDLE
start  in  1  job request pulse from controller
a_in  in  DATA_W  signed operand from west
b_in  in  DATA_W  signed operand from north
a_out  out  DATA_W  a_in registered one cycle, to east neighbour
b_out  out  DATA_W  b_in registered one cycle, to south neighbour
acc_out  out  ACC_W  accumulator value (registered)
busy  out  1  high in RUN and WAIT
done  out  1  one-cycle pulse, first cycle after last MAC
delayed_done  out  1  one-cycle pulse, DONE_DELAY cycles after done
ovf  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (rst=1 at an edge): all outputs go to 0, state goes to IDLE and counters clear. Applies from any state, including mid-job; no done or delayed_done is produced for the aborted job.
- a_out and b_out forward a_in and b_in every cycle in every state except during reset.
- State machine: IDLE, RUN, WAIT.
  - IDLE:
    - clr=1 sets acc_out and ovf to 0.
    - Otherwise, start=1 moves to RUN with k_cnt=0.
    - If clr and start are both high, clr is applied and start is also accepted.
  - RUN:
    - Each cycle: acc_out <= acc_out + sext(a_in*b_in), and k_cnt increments.
    - After the K_LEN-th MAC, go to WAIT with d_cnt=0.
  - WAIT:
    - done=1 in the first WAIT cycle only.
    - d_cnt increments each cycle; when d_cnt reaches DONE_DELAY-1, return to IDLE.
    - delayed_done=1 is registered, so it is visible in the first IDLE cycle after WAIT.
- Timing, with start sampled at edge t:
  - MACs use the operands present in cycles t+1..t+K_LEN.
  - done is high in cycle t+K_LEN+1, and acc_out is final in that cycle.
  - delayed_done is high in cycle t+K_LEN+1+DONE_DELAY.
- start is not a clear: each job accumulates onto the existing acc_out. Clearing is the job of clr.
- start and clr are ignored in RUN and WAIT; no queueing.
- A start coincident with delayed_done (first IDLE cycle) is accepted, allowing back-to-back jobs.
- Products are full 2*DATA_W signed and sign-extended to ACC_W. Without the optional feature, addition wraps two's-complement modulo 2^ACC_W.

Optional Feature:
Macro PE_SATURATE_EN.
- Defined: accumulation saturates to the signed ACC_W range, i.e. max 2^(ACC_W-1)-1 and min -2^(ACC_W-1). ovf is set to 1 on any clamp and stays set until rst or clr in IDLE.
- Not defined: accumulation wraps and ovf is tied to 0.

Test Plan:
- Defaults, acc=0. Pulse start, then drive a=1,2,3,4 with b=5,6,7,8 on the next 4 cycles -> acc_out=70; done at start+5; delayed_done at start+7; busy high for cycles start+1..start+6.
- Second job with no clr, a=-3 for all 4 cycles and b=4 -> acc_out=70-48=22. Then clr in IDLE -> acc_out=0 on the next cycle.
- Stream a=0x11, 0x22, 0x33 -> a_out shows the same values exactly one cycle later, in all states.
- start pulsed again during RUN and during WAIT -> ignored; exactly one done and one delayed_done; result unchanged.
- rst asserted at start+2 mid-job -> next cycle state IDLE, acc_out=0, busy=0; no done or delayed_done for the aborted job; a following start runs normally.
- ACC_W=16, a=127 and b=127 for 4 MACs -> with PE_SATURATE_EN: acc_out=32767 and ovf=1. Without it: acc_out=-1020 and ovf=0.
